// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller.
// Contents: access-size and FSM state encodings, the latched request record,
// and the lane helpers used for store byte enables, store data replication
// and load extraction.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        HB_BYTE = 2'b00,
        HB_HALF = 2'b01,
        HB_WORD = 2'b10,
        HB_RSVD = 2'b11
    } hb_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10,
        ST_ERROR  = 2'b11
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        hb_e         hb;
    } lsu_req_t;

    // Byte-write enables for a store of size hb at byte offset a.
    function automatic logic [3:0] lane_be(input hb_e hb, input logic [1:0] a);
        logic [3:0] be;
        case (hb)
            HB_BYTE: be = 4'b0001 << a;
            HB_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            HB_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data copied into every lane it could land in,
    // so the byte enables alone decide what is written.
    function automatic logic [31:0] lane_wdata(input hb_e hb, input logic [31:0] wd);
        logic [31:0] r;
        case (hb)
            HB_BYTE: r = {4{wd[7:0]}};
            HB_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed lane down to bit 0 and sign-extend it.
    function automatic logic [31:0] load_fmt(input hb_e hb, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (hb)
            HB_BYTE: r = {{24{b[7]}}, b};
            HB_HALF: r = {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Load/store unit <-> data-memory controller bus.
//   addr/wdata/we/hb/req : request from the LSU (held until gnt)
//   rdata/gnt/err        : single-cycle completion from the controller
interface dmem_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  hb;
    logic        req;
    logic [31:0] rdata;
    logic        gnt;
    logic        err;

    modport master (output addr, wdata, we, hb, req, input  rdata, gnt, err);
    modport slave  (input  addr, wdata, we, hb, req, output rdata, gnt, err);
endinterface

// File: rtl/dmem_sram.sv
// Single-port data RAM, DEPTH_WORDS x 32, byte-write enables, registered read.
//   clk   : clock
//   en    : perform an access this edge (read always, write lanes per be)
//   be    : byte-write enables, bit n covers wdata[8n+7:8n]
//   idx   : word index
//   wdata : write data
//   rdata : read data, valid the cycle after an enabled access
// Contents are deliberately not reset.
module dmem_sram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [3:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) mem[idx][l] <= wdata[l*8 +: 8];
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one LSU load/store at a time, checks size,
// alignment and range, steers store lanes into the RAM and formats load data.
//   i_clk : core clock
//   i_rst : asynchronous active-high reset
//   lsu   : LSU request/completion bus (slave side)
// Legal requests complete with gnt two cycles after sampling, illegal ones
// with gnt+err one cycle after sampling.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    dmem_ctrl_if.slave  lsu
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state, state_nxt;
    lsu_req_t    req_q;
    logic        legal;
    logic [31:0] off_in, off_q;
    logic        ram_en;
    logic [3:0]  ram_be;
    logic [AW-1:0] ram_idx;
    logic [31:0] ram_wdata, ram_rdata;

    // Legality of the live request; only consulted in IDLE.
    always_comb begin
        off_in = lsu.addr - BASE_ADDR;
        legal  = 1'b1;
        case (lsu.hb)
            HB_RSVD: legal = 1'b0;
            HB_HALF: if (lsu.addr[0]) legal = 1'b0;
            HB_WORD: if (lsu.addr[1:0] != 2'b00) legal = 1'b0;
            default: ;
        endcase
        // Addresses below BASE_ADDR wrap to large offsets and fail here too.
        if ((off_in >> (AW + 2)) != 32'd0) legal = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            req_q <= '0;
        else if (state == ST_IDLE && lsu.req && legal)
            req_q <= '{addr: lsu.addr, wdata: lsu.wdata, we: lsu.we, hb: hb_e'(lsu.hb)};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (lsu.req) state_nxt = legal ? ST_ACCESS : ST_ERROR;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        lsu.gnt   = 1'b0;
        lsu.err   = 1'b0;
        lsu.rdata = '0;
        case (state)
            ST_RESP: begin
                lsu.gnt = 1'b1;
                if (!req_q.we) lsu.rdata = load_fmt(req_q.hb, req_q.addr[1:0], ram_rdata);
            end
            ST_ERROR: begin
                lsu.gnt = 1'b1;
                lsu.err = 1'b1;
            end
            default: ;
        endcase
    end

    // The RAM op fires on the edge leaving ACCESS. Reset is ANDed in so an
    // async reset landing in ACCESS cannot let the store through on that edge.
    always_comb begin
        off_q     = req_q.addr - BASE_ADDR;
        ram_idx   = AW'(off_q >> 2);
        ram_en    = (state == ST_ACCESS) && !i_rst;
        ram_be    = (ram_en && req_q.we) ? lane_be(req_q.hb, req_q.addr[1:0]) : 4'b0000;
        ram_wdata = lane_wdata(req_q.hb, req_q.wdata);
    end

    dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (i_clk),
        .en    (ram_en),
        .be    (ram_be),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule
